// File: rtl/cnn_layer_accel_weight_loader_pkg.sv
// Shared definitions for the CE weight path: weight geometry, 3x3 kernel sizing,
// loader state encoding (reused by the CE controller) and a constant clog2 helper.
// No logic; imported by the weight loader and its neighbours.
package cnn_layer_accel_weight_loader_pkg;

  localparam int WEIGHT_WIDTH                  = 16;
  localparam int MAX_BRAM_3x3_KERNELS          = 64;
  localparam int KERNEL_3x3_COUNT_FULL         = 9;
  localparam int KERNEL_3x3_COUNT_FULL_MINUS_1 = KERNEL_3x3_COUNT_FULL - 1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

  localparam int C_CLG2_MAX_BRAM_3x3_KERNELS = clog2(MAX_BRAM_3x3_KERNELS);

  // Loader state encoding, kept here so the CE controller decodes the same values.
  localparam logic [1:0] WL_ST_IDLE = 2'd0;
  localparam logic [1:0] WL_ST_LOAD = 2'd1;
  localparam logic [1:0] WL_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = WL_ST_IDLE,
    ST_LOAD = WL_ST_LOAD,
    ST_DONE = WL_ST_DONE
  } wl_state_t;

endpackage

// File: rtl/cnn_layer_accel_weight_loader.sv
// Unpacks C_LANES-wide weight beats into single-weight writes on the CE weight table config port.
// Latency: start -> config_mode next cycle; beat accepted -> its lane 0 written next cycle.
// Backpressure: wht_in_ready only from registered state; a one-beat hold register drains lane by lane.
// Optional WHT_LOADER_CKSUM_EN adds a 16-bit running sum of written weights on wht_cksum.
module cnn_layer_accel_weight_loader
  import cnn_layer_accel_weight_loader_pkg::*;
#(
  parameter int C_IN_WIDTH = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [C_CLG2_MAX_BRAM_3x3_KERNELS-1:0] num_kernels,
  input  logic                                   wht_in_valid,
  output logic                                   wht_in_ready,
  input  logic [C_IN_WIDTH-1:0]                  wht_in_data,
  output logic                                   config_mode,
  output logic                                   wht_config_wren,
  output logic [WEIGHT_WIDTH-1:0]                wht_config_data,
  output logic                                   busy,
  output logic                                   load_done,
  output logic [15:0]                            wht_cksum
);

  localparam int C_LANES  = C_IN_WIDTH / WEIGHT_WIDTH;
  localparam int C_LANE_W = (clog2(C_LANES) < 1) ? 1 : clog2(C_LANES);
  localparam int KRN_W    = C_CLG2_MAX_BRAM_3x3_KERNELS;

  localparam logic [C_LANE_W-1:0] LANE_LAST = C_LANE_W'(C_LANES - 1);
  localparam logic [3:0]          WHT_LAST  = 4'(KERNEL_3x3_COUNT_FULL_MINUS_1);

  typedef logic [C_LANES-1:0][WEIGHT_WIDTH-1:0] beat_t;

  wl_state_t              state;
  logic [KRN_W-1:0]       nk_q;
  logic [C_LANE_W-1:0]    lane_cnt;
  logic [3:0]             wht_cnt;
  logic [KRN_W-1:0]       krn_cnt;
  beat_t                  hold_data;
  logic                   hold_valid;
  logic                   final_done;

  logic                   at_final;
  logic                   lane_last;
  logic                   consuming;
  logic                   final_beat_taken;
  logic                   accept;
  logic                   do_write;
  logic [WEIGHT_WIDTH-1:0] wr_data;

  // Next-write decode: everything here comes from registered state except accept.
  always_comb begin
    at_final         = (krn_cnt == nk_q) && (wht_cnt == WHT_LAST);
    lane_last        = (lane_cnt == LANE_LAST);
    consuming        = hold_valid && (lane_last || at_final);
    final_beat_taken = final_done || (hold_valid && at_final);
    wht_in_ready     = (state == ST_LOAD) && (!hold_valid || consuming) && !final_beat_taken;
    accept           = wht_in_valid && wht_in_ready;
    do_write         = (state == ST_LOAD) && !final_done && (hold_valid || accept);
    // An empty hold register lets an accepted beat write its lane 0 straight through.
    wr_data          = hold_valid ? hold_data[lane_cnt] : wht_in_data[WEIGHT_WIDTH-1:0];
  end

  assign busy = (state != ST_IDLE);

  // Control FSM with counters, hold register and registered config-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      nk_q            <= '0;
      lane_cnt        <= '0;
      wht_cnt         <= '0;
      krn_cnt         <= '0;
      hold_data       <= '0;
      hold_valid      <= 1'b0;
      final_done      <= 1'b0;
      config_mode     <= 1'b0;
      wht_config_wren <= 1'b0;
      wht_config_data <= '0;
      load_done       <= 1'b0;
    end else begin
      wht_config_wren <= 1'b0;
      load_done       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD;
            nk_q        <= num_kernels;
            lane_cnt    <= '0;
            wht_cnt     <= '0;
            krn_cnt     <= '0;
            hold_data   <= '0;
            hold_valid  <= 1'b0;
            final_done  <= 1'b0;
            config_mode <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (final_done) begin
            // Final weight is on the port this cycle; drop config_mode with the done pulse.
            state       <= ST_DONE;
            config_mode <= 1'b0;
            load_done   <= 1'b1;
          end else begin
            if (do_write) begin
              wht_config_wren <= 1'b1;
              wht_config_data <= wr_data;
              final_done      <= at_final;
              if (wht_cnt == WHT_LAST) begin
                wht_cnt <= '0;
                krn_cnt <= krn_cnt + KRN_W'(1);
              end else begin
                wht_cnt <= wht_cnt + 4'd1;
              end
            end
            if (hold_valid) begin
              if (accept) begin
                // Last lane of the held beat goes out now; the new beat starts at lane 0.
                hold_data <= wht_in_data;
                lane_cnt  <= '0;
              end else if (consuming) begin
                hold_valid <= 1'b0;
                lane_cnt   <= '0;
              end else begin
                lane_cnt <= lane_cnt + C_LANE_W'(1);
              end
            end else if (accept) begin
              // Lane 0 already written; keep the rest unless it was the final weight.
              if (at_final || (C_LANES == 1)) begin
                hold_valid <= 1'b0;
                lane_cnt   <= '0;
              end else begin
                hold_data  <= wht_in_data;
                hold_valid <= 1'b1;
                lane_cnt   <= C_LANE_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WHT_LOADER_CKSUM_EN
  logic [15:0] cksum_q;

  // Running modulo-2^16 sum of written weights, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      cksum_q <= '0;
    end else if (do_write) begin
      cksum_q <= cksum_q + 16'(wr_data);
    end
  end

  assign wht_cksum = cksum_q;
`else
  assign wht_cksum = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Directed self-checking bench for cnn_layer_accel_weight_loader (C_IN_WIDTH=64, 9 weights/kernel).
// Inputs driven 1 time unit after posedge; outputs and handshakes sampled on negedge.
// WHT_LOADER_CKSUM_EN selects the expected checksum behaviour.
module tb_cnn_layer_accel_weight_loader;
  import cnn_layer_accel_weight_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  num_kernels;
  logic        wht_in_valid;
  logic        wht_in_ready;
  logic [63:0] wht_in_data;
  logic        config_mode;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic        busy;
  logic        load_done;
  logic [15:0] wht_cksum;

  cnn_layer_accel_weight_loader #(.C_IN_WIDTH(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_kernels     (num_kernels),
    .wht_in_valid    (wht_in_valid),
    .wht_in_ready    (wht_in_ready),
    .wht_in_data     (wht_in_data),
    .config_mode     (config_mode),
    .wht_config_wren (wht_config_wren),
    .wht_config_data (wht_config_data),
    .busy            (busy),
    .load_done       (load_done),
    .wht_cksum       (wht_cksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] wts [0:63];
  logic [15:0] wr_q [$];
  int          beats_acc;
  int          cm_cycles;
  int          cm_bad;
  int          first_wr_cycle;
  int          last_wr_cycle;
  int          done_cycle;
  int          done_pulses;
  logic        cm_at_done;
  logic [15:0] ck_at_done;
  logic [15:0] ck_any;

  function automatic logic [63:0] beat_of(input int bi);
    logic [63:0] b;
    b = '0;
    for (int l = 0; l < 4; l++) begin
      if (4 * bi + l < 64) b[16*l +: 16] = wts[4*bi + l];
    end
    return b;
  endfunction

  // Runs one load; stops early once stop_after writes were seen (0 = run to load_done).
  task automatic do_load(input int nk, input bit starve, input int mid_start_at, input int stop_after);
    int  cyc;
    int  bi;
    bit  fin;
    bit  acc;
    wr_q.delete();
    beats_acc = 0; cm_cycles = 0; cm_bad = 0; first_wr_cycle = -1; last_wr_cycle = -1;
    done_cycle = -1; done_pulses = 0; cm_at_done = 1'b1; ck_at_done = '0; ck_any = '0;
    @(posedge clk); #1;
    wht_in_valid = 1'b0;
    num_kernels  = 6'(nk);
    start        = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    num_kernels = 6'h3f;
    cyc = 0; bi = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      wht_in_valid = starve ? (cyc % 2 == 0) : 1'b1;
      wht_in_data  = beat_of(bi);
      if (cyc == mid_start_at) begin
        start = 1'b1; num_kernels = 6'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = wht_in_valid && wht_in_ready;
      if (acc) beats_acc++;
      ck_any = ck_any | wht_cksum;
      if (config_mode) cm_cycles++;
      if (wht_config_wren) begin
        wr_q.push_back(wht_config_data);
        if (first_wr_cycle < 0) first_wr_cycle = cyc;
        last_wr_cycle = cyc;
        if (!config_mode) cm_bad++;
      end
      if (load_done) begin
        done_pulses++;
        done_cycle = cyc;
        cm_at_done = config_mode;
        ck_at_done = wht_cksum;
        fin = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) bi++;
      if (stop_after > 0 && wr_q.size() >= stop_after) fin = 1'b1;
      cyc++;
    end
    start = 1'b0;
    wht_in_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL load_timeout: no load_done within %0d cycles (writes seen %0d)", cyc, wr_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_kernels = '0; wht_in_valid = 1'b0; wht_in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (wht_in_ready !== 1'b0)    begin errors++; $display("FAIL rst_ready: got %b want 0", wht_in_ready); end
    checks++; if (config_mode !== 1'b0)     begin errors++; $display("FAIL rst_config_mode: got %b want 0", config_mode); end
    checks++; if (wht_config_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", wht_config_wren); end
    checks++; if (wht_config_data !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", wht_config_data); end
    checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (load_done !== 1'b0)       begin errors++; $display("FAIL rst_load_done: got %b want 0", load_done); end
    checks++; if (wht_cksum !== 16'h0)      begin errors++; $display("FAIL rst_cksum: got %h want 0000", wht_cksum); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_kernel();
    logic [15:0] exp_ck;
    for (int i = 0; i < 64; i++) wts[i] = 16'(i + 1);
    do_load(0, 1'b0, -1, 0);
    checks++; if (wr_q.size() != 9) begin errors++; $display("FAIL single_write_count: got %0d want 9", wr_q.size()); end
    for (int i = 0; i < 9 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== 16'(i + 1)) begin errors++; $display("FAIL single_data[%0d]: got %0d want %0d", i, wr_q[i], i + 1); end
    end
    checks++; if (beats_acc != 3) begin errors++; $display("FAIL single_beats: got %0d want 3", beats_acc); end
    checks++; if (first_wr_cycle != 1) begin errors++; $display("FAIL single_first_latency: got cycle %0d want 1", first_wr_cycle); end
    checks++; if (last_wr_cycle - first_wr_cycle != 8) begin errors++; $display("FAIL single_back_to_back: span %0d want 8", last_wr_cycle - first_wr_cycle); end
    checks++; if (done_cycle != last_wr_cycle + 1) begin errors++; $display("FAIL single_done_timing: done %0d want %0d", done_cycle, last_wr_cycle + 1); end
    checks++; if (cm_at_done !== 1'b0) begin errors++; $display("FAIL single_cm_at_done: got %b want 0", cm_at_done); end
    checks++; if (cm_cycles != last_wr_cycle + 1) begin errors++; $display("FAIL single_cm_span: got %0d want %0d", cm_cycles, last_wr_cycle + 1); end
    checks++; if (cm_bad != 0) begin errors++; $display("FAIL single_cm_on_write: %0d writes without config_mode, want 0", cm_bad); end
`ifdef WHT_LOADER_CKSUM_EN
    exp_ck = 16'd45;
`else
    exp_ck = 16'd0;
`endif
    checks++; if (ck_at_done !== exp_ck) begin errors++; $display("FAIL single_cksum: got %h want %h", ck_at_done, exp_ck); end
    @(negedge clk);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", load_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: busy %b want 0", busy); end
  endtask

  task automatic test_four_kernels();
    logic [15:0] tbl [0:3][0:8];
    int wraps;
    for (int i = 0; i < 64; i++) wts[i] = 16'(100 + i);
    do_load(3, 1'b0, -1, 0);
    checks++; if (wr_q.size() != 36) begin errors++; $display("FAIL four_write_count: got %0d want 36", wr_q.size()); end
    checks++; if (beats_acc != 9) begin errors++; $display("FAIL four_beats: got %0d want 9", beats_acc); end
    wraps = 0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 9; j++) tbl[k][j] = 16'hdead;
    for (int i = 0; i < wr_q.size() && i < 36; i++) begin
      tbl[i / 9][i % 9] = wr_q[i];
      if (i % 9 == 8) wraps++;
    end
    checks++; if (wraps != 4) begin errors++; $display("FAIL four_wraps: got %0d want 4", wraps); end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (tbl[k][j] !== 16'(100 + 9 * k + j)) begin
          errors++; $display("FAIL four_table[%0d][%0d]: got %0d want %0d", k, j, tbl[k][j], 100 + 9 * k + j);
        end
      end
    end
    checks++; if (done_cycle != last_wr_cycle + 1) begin errors++; $display("FAIL four_done_timing: done %0d want %0d", done_cycle, last_wr_cycle + 1); end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 64; i++) wts[i] = 16'(16'h1000 + i);
    do_load(1, 1'b1, -1, 0);
    checks++; if (wr_q.size() != 18) begin errors++; $display("FAIL starve_write_count: got %0d want 18", wr_q.size()); end
    for (int i = 0; i < 18 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== 16'(16'h1000 + i)) begin errors++; $display("FAIL starve_data[%0d]: got %h want %h", i, wr_q[i], 16'(16'h1000 + i)); end
    end
    checks++; if (beats_acc != 5) begin errors++; $display("FAIL starve_beats: got %0d want 5", beats_acc); end
    checks++; if (cm_cycles != last_wr_cycle + 1) begin errors++; $display("FAIL starve_cm_held: got %0d want %0d", cm_cycles, last_wr_cycle + 1); end
    checks++; if (cm_bad != 0) begin errors++; $display("FAIL starve_cm_on_write: %0d want 0", cm_bad); end
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < 64; i++) wts[i] = 16'(16'h0200 + 3 * i);
    do_load(0, 1'b0, 4, 0);
    checks++; if (wr_q.size() != 9) begin errors++; $display("FAIL ign_write_count: got %0d want 9", wr_q.size()); end
    for (int i = 0; i < 9 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== 16'(16'h0200 + 3 * i)) begin errors++; $display("FAIL ign_data[%0d]: got %h want %h", i, wr_q[i], 16'(16'h0200 + 3 * i)); end
    end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL ign_done_pulses: got %0d want 1", done_pulses); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_after: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 64; i++) wts[i] = 16'(i + 1);
    do_load(0, 1'b0, -1, 5);
    checks++; if (wr_q.size() != 5) begin errors++; $display("FAIL mid_writes_before_rst: got %0d want 5", wr_q.size()); end
    wht_in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wht_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (wht_config_wren !== 1'b0) begin errors++; $display("FAIL mid_rst_wren: got %b want 0", wht_config_wren); end
    checks++; if (config_mode !== 1'b0) begin errors++; $display("FAIL mid_rst_config_mode: got %b want 0", config_mode); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (wht_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", wht_in_ready); end
    checks++; if (wht_config_data !== 16'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 0000", wht_config_data); end
    checks++; if (wht_cksum !== 16'h0) begin errors++; $display("FAIL mid_rst_cksum: got %h want 0000", wht_cksum); end
    do_load(0, 1'b0, -1, 0);
    checks++; if (wr_q.size() != 9) begin errors++; $display("FAIL mid_reload_count: got %0d want 9", wr_q.size()); end
    for (int i = 0; i < 9 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== 16'(i + 1)) begin errors++; $display("FAIL mid_reload_data[%0d]: got %0d want %0d", i, wr_q[i], i + 1); end
    end
    checks++; if (beats_acc != 3) begin errors++; $display("FAIL mid_reload_beats: got %0d want 3", beats_acc); end
  endtask

  task automatic test_checksum();
    for (int i = 0; i < 64; i++) wts[i] = 16'hFFFF;
    do_load(0, 1'b0, -1, 0);
`ifdef WHT_LOADER_CKSUM_EN
    checks++; if (ck_at_done !== 16'hFFF7) begin errors++; $display("FAIL cksum_at_done: got %h want fff7", ck_at_done); end
    @(negedge clk);
    checks++; if (wht_cksum !== 16'hFFF7) begin errors++; $display("FAIL cksum_stable: got %h want fff7", wht_cksum); end
`else
    checks++; if (ck_any !== 16'h0) begin errors++; $display("FAIL cksum_disabled: got %h want 0000", ck_any); end
    @(negedge clk);
    checks++; if (wht_cksum !== 16'h0) begin errors++; $display("FAIL cksum_disabled_after: got %h want 0000", wht_cksum); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_kernel();
    test_four_kernels();
    test_starvation();
    test_ignored_start();
    test_reset_mid_load();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
